i2c_arbiter: RTL and testbench

- Shares one I2C master engine between N_REQ requesters (one per ToF sensor driver) using round-robin arbitration.
- Latches the granted requester's command, pulses the engine start and routes write-byte requests and read data.
- Reports done or error per requester and recovers a hung engine with a watchdog.
- Sits between the ToF sensor drivers and the I2C master in the ToF_Drivers hierarchy.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_arbiter_if.sv | 51 +++++
 rtl/rr_picker.sv | 31 +++
 rtl/i2c_arbiter.sv | 178 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and field widths for the I2C engine arbiter.
package i2c_pkg;

  localparam int unsigned ADDR7_W = 7;
  localparam int unsigned REG_W   = 16;
  localparam int unsigned NB_W    = 17;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RDATA_W = 16;
  localparam int unsigned WDOG_W  = 22;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLaunch,
    StWait,
    StRecover,
    StRelease
  } state_e;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester and engine signals of the arbiter, grouped in one bundle.
interface i2c_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();
  import i2c_pkg::*;

  // Requester side
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         req_is_read;
  logic [ADDR7_W*N_REQ-1:0] req_slave_addr;
  logic [REG_W*N_REQ-1:0]   req_reg_addr;
  logic [NB_W*N_REQ-1:0]    req_nb_bytes;
  logic [DATA_W*N_REQ-1:0]  req_wdata;
  logic [N_REQ-1:0]         grant;
  logic [N_REQ-1:0]         wdata_req;
  logic [N_REQ-1:0]         done;
  logic [N_REQ-1:0]         err;
  logic [RDATA_W-1:0]       rdata;

  // Engine side
  logic                     eng_start;
  logic                     eng_reset;
  logic [ADDR7_W-1:0]       eng_slave_addr;
  logic [REG_W-1:0]         eng_reg_addr;
  logic                     eng_is_read;
  logic [NB_W-1:0]          eng_nb_bytes;
  logic [DATA_W-1:0]        eng_data_in;
  logic                     eng_data_req;
  logic                     eng_ready;
  logic                     eng_error;
  logic [RDATA_W-1:0]       eng_data_out;

  // Arbiter view
  modport slave (
    input  req, req_is_read, req_slave_addr, req_reg_addr, req_nb_bytes, req_wdata,
    input  eng_data_req, eng_ready, eng_error, eng_data_out,
    output grant, wdata_req, done, err, rdata,
    output eng_start, eng_reset, eng_slave_addr, eng_reg_addr, eng_is_read, eng_nb_bytes,
    output eng_data_in
  );

  // Requesters plus engine view
  modport master (
    output req, req_is_read, req_slave_addr, req_reg_addr, req_nb_bytes, req_wdata,
    output eng_data_req, eng_ready, eng_error, eng_data_out,
    input  grant, wdata_req, done, err, rdata,
    input  eng_start, eng_reset, eng_slave_addr, eng_reg_addr, eng_is_read, eng_nb_bytes,
    input  eng_data_in
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] j;

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    j        = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = IdxW'((32'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[j]) begin
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin owner of a shared I2C master engine, with watchdog recovery.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned RECOVER_CYCLES = 4
) (
  input logic          clock,
  input logic          reset,
  i2c_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned RecW = $clog2(RECOVER_CYCLES + 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d, gidx_q, gidx_d;
  logic [N_REQ-1:0]     grant_q, grant_d, wdata_req_q, wdata_req_d;
  logic [N_REQ-1:0]     done_q, done_d, err_q, err_d;
  logic [RDATA_W-1:0]   rdata_q, rdata_d;
  logic                 eng_start_q, eng_start_d, is_read_q, is_read_d;
  logic [ADDR7_W-1:0]   slave_addr_q, slave_addr_d;
  logic [REG_W-1:0]     reg_addr_q, reg_addr_d;
  logic [NB_W-1:0]      nb_bytes_q, nb_bytes_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [RecW-1:0]      rec_cnt_q, rec_cnt_d;

  logic                 pick_valid;
  logic [N_REQ-1:0]     pick_onehot;
  logic [IdxW-1:0]      pick_idx;

  logic [ADDR7_W-1:0]   sa_arr [N_REQ];
  logic [REG_W-1:0]     ra_arr [N_REQ];
  logic [NB_W-1:0]      nb_arr [N_REQ];
  logic [DATA_W-1:0]    wd_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign sa_arr[g] = bus.req_slave_addr[g*ADDR7_W +: ADDR7_W];
    assign ra_arr[g] = bus.req_reg_addr[g*REG_W +: REG_W];
    assign nb_arr[g] = bus.req_nb_bytes[g*NB_W +: NB_W];
    assign wd_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_picker (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  // Next-state and registered outputs of the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    grant_d      = grant_q;
    wdata_req_d  = '0;
    done_d       = '0;
    err_d        = '0;
    rdata_d      = rdata_q;
    eng_start_d  = 1'b0;
    is_read_d    = is_read_q;
    slave_addr_d = slave_addr_q;
    reg_addr_d   = reg_addr_q;
    nb_bytes_d   = nb_bytes_q;
    wdog_d       = wdog_q;
    rec_cnt_d    = rec_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) state_d = StArb;
      end
      StArb: begin
        if (pick_valid) begin
          grant_d = pick_onehot;
          gidx_d  = pick_idx;
          ptr_d   = (pick_idx == IdxW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          // Command and start/err are registered on entry so they are valid
          // throughout the LAUNCH cycle.
          slave_addr_d = sa_arr[pick_idx];
          reg_addr_d   = ra_arr[pick_idx];
          nb_bytes_d   = nb_arr[pick_idx];
          is_read_d    = bus.req_is_read[pick_idx];
          if (nb_arr[pick_idx] == '0) err_d = pick_onehot;
          else eng_start_d = 1'b1;
          state_d = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      StLaunch: begin
        wdog_d  = '0;
        state_d = (nb_bytes_q == '0) ? StRelease : StWait;
      end
      StWait: begin
        wdata_req_d = bus.eng_data_req ? grant_q : '0;
        if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
        if (bus.eng_error) begin
          err_d     = grant_q;
          rec_cnt_d = '0;
          state_d   = StRecover;
        end else if (bus.eng_ready) begin
          done_d = grant_q;
          if (is_read_q) rdata_d = bus.eng_data_out;
          state_d = StRelease;
        end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          err_d     = grant_q;
          rec_cnt_d = '0;
          state_d   = StRecover;
        end
      end
      StRecover: begin
        if (rec_cnt_q == RecW'(RECOVER_CYCLES - 1)) state_d = StRelease;
        else rec_cnt_d = rec_cnt_q + 1'b1;
      end
      StRelease: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      gidx_q       <= '0;
      grant_q      <= '0;
      wdata_req_q  <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      eng_start_q  <= 1'b0;
      is_read_q    <= 1'b0;
      slave_addr_q <= '0;
      reg_addr_q   <= '0;
      nb_bytes_q   <= '0;
      wdog_q       <= '0;
      rec_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      grant_q      <= grant_d;
      wdata_req_q  <= wdata_req_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      eng_start_q  <= eng_start_d;
      is_read_q    <= is_read_d;
      slave_addr_q <= slave_addr_d;
      reg_addr_q   <= reg_addr_d;
      nb_bytes_q   <= nb_bytes_d;
      wdog_q       <= wdog_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.wdata_req      = wdata_req_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.eng_start      = eng_start_q;
  assign bus.eng_reset      = reset | (state_q == StRecover);
  assign bus.eng_slave_addr = slave_addr_q;
  assign bus.eng_reg_addr   = reg_addr_q;
  assign bus.eng_is_read    = is_read_q;
  assign bus.eng_nb_bytes   = nb_bytes_q;
  assign bus.eng_data_in    = (|grant_q) ? wd_arr[gidx_q] : '0;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Randomised bench for i2c_arbiter against a transaction-level reference model.
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int NReq = 4;
  localparam int Tmo  = 100;
  localparam int Rec  = 4;
  localparam int ModeOk  = 0;
  localparam int ModeErr = 1;
  localparam int ModeTmo = 2;
  localparam int ModeRst = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  i2c_arbiter_if #(.N_REQ(NReq)) bus ();

  i2c_arbiter #(
    .N_REQ          (NReq),
    .TIMEOUT_CYCLES (Tmo),
    .RECOVER_CYCLES (Rec)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending requests, their commands, RR pointer, last read.
  logic        pend   [NReq];
  logic        m_read [NReq];
  logic [6:0]  m_sa   [NReq];
  logic [15:0] m_ra   [NReq];
  logic [16:0] m_nb   [NReq];
  logic [7:0]  m_wd   [NReq];
  int          ptr_m;
  logic [15:0] rdata_m;

  function automatic int rr_pick();
    for (int i = 0; i < NReq; i++) begin
      if (pend[(ptr_m + i) % NReq]) return (ptr_m + i) % NReq;
    end
    return -1;
  endfunction

  function automatic logic [16:0] rand_nb();
    if ($urandom_range(0, 7) == 0) return 17'd0;
    return 17'($urandom_range(1, 300));
  endfunction

  task automatic new_cmd(input int r, input logic rd, input logic [16:0] nb);
    pend[r]   = 1'b1;
    m_read[r] = rd;
    m_sa[r]   = 7'($urandom);
    m_ra[r]   = 16'($urandom);
    m_nb[r]   = nb;
    m_wd[r]   = 8'($urandom);
  endtask

  task automatic apply_req();
    for (int r = 0; r < NReq; r++) begin
      bus.req[r]                  = pend[r];
      bus.req_is_read[r]          = m_read[r];
      bus.req_slave_addr[r*7 +: 7]  = m_sa[r];
      bus.req_reg_addr[r*16 +: 16]  = m_ra[r];
      bus.req_nb_bytes[r*17 +: 17]  = m_nb[r];
      bus.req_wdata[r*8 +: 8]       = m_wd[r];
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", bus.grant, 0);
    check("rst_done_err", bus.done | bus.err, 0);
    check("rst_wdata_req", bus.wdata_req, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_start", bus.eng_start, 0);
    check("rst_eng_reset", bus.eng_reset, 1);
    check("rst_fields", {bus.eng_slave_addr, bus.eng_is_read, bus.eng_data_in}, 0);
    check("rst_fields2", {bus.eng_reg_addr, bus.eng_nb_bytes}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    reset   = 1'b0;
    ptr_m   = 0;
    rdata_m = '0;
  endtask

  // Called at a negedge in RECOVER cycle 1; returns at the following IDLE negedge.
  task automatic recover_tail();
    int cnt;
    cnt = int'(bus.eng_reset);
    repeat (4) begin
      @(negedge clock);
      cnt += int'(bus.eng_reset);
      check("no_done_in_recover", bus.done, 0);
    end
    bus.eng_error = 1'b1;  // stray strobe outside WAIT
    @(negedge clock);
    bus.eng_error = 1'b0;
    check("recover_cycles", cnt, Rec);
    check("release_grant", bus.grant, 0);
    check("stray_err_ignored", bus.err, 0);
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic serve_round(input int mode, input int nstrob, input logic [15:0] rval);
    int   w;
    int   lat;
    int   n;
    logic got;
    apply_req();
    w = rr_pick();
    if (w < 0) return;
    lat = 0;
    got = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clock);
      lat++;
      if (bus.grant != 0) got = 1'b1;
      else check("no_pulse_before_grant", bus.done | bus.err, 0);
    end
    check("launch_latency", lat, 2);
    if (!got) return;
    check("grant", bus.grant, 32'(1) << w);
    ptr_m = (w + 1) % NReq;
    check("eng_slave_addr", bus.eng_slave_addr, m_sa[w]);
    check("eng_reg_addr", bus.eng_reg_addr, m_ra[w]);
    check("eng_nb_bytes", bus.eng_nb_bytes, m_nb[w]);
    check("eng_is_read", bus.eng_is_read, m_read[w]);
    if (m_nb[w] == 0) begin
      check("zero_len_no_start", bus.eng_start, 0);
      check("zero_len_err", bus.err, 32'(1) << w);
      pend[w] = 1'b0;
      apply_req();
      @(negedge clock);
      check("zero_len_start_never", bus.eng_start, 0);
      @(negedge clock);
      check("release_grant", bus.grant, 0);
      return;
    end
    check("eng_start", bus.eng_start, 1);
    check("launch_no_err", bus.err, 0);
    if (mode == ModeOk) begin
      for (int k = 0; k < nstrob; k++) begin
        @(negedge clock);
        bus.eng_data_req = 1'b1;
        bus.eng_data_out = 16'($urandom);
        @(negedge clock);
        bus.eng_data_req = 1'b0;
        check("wdata_req", bus.wdata_req, 32'(1) << w);
        check("eng_data_in", bus.eng_data_in, m_wd[w]);
        check("rdata_hold", bus.rdata, rdata_m);
      end
      if ($urandom_range(0, 3) == 0) begin
        pend[w] = 1'b0;  // requester drops mid-transaction
        apply_req();
      end
      @(negedge clock);
      bus.eng_ready    = 1'b1;
      bus.eng_data_out = rval;
      @(negedge clock);
      bus.eng_ready = 1'b0;
      if (m_read[w]) rdata_m = rval;
      check("done", bus.done, 32'(1) << w);
      check("done_no_err", bus.err, 0);
      check("rdata", bus.rdata, rdata_m);
      check("grant_at_done", bus.grant, 32'(1) << w);
      pend[w] = 1'b0;
      apply_req();
      @(negedge clock);
      check("release_grant", bus.grant, 0);
      check("done_single", bus.done, 0);
    end else if (mode == ModeErr) begin
      @(negedge clock);
      bus.eng_error = 1'b1;
      bus.eng_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      bus.eng_error = 1'b0;
      bus.eng_ready = 1'b0;
      check("nack_err", bus.err, 32'(1) << w);
      check("nack_no_done", bus.done, 0);
      check("nack_eng_reset", bus.eng_reset, 1);
      pend[w] = 1'b0;
      apply_req();
      recover_tail();
    end else if (mode == ModeTmo) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (bus.err == 0 && n < Tmo + 10);
      check("timeout_cycles", n, Tmo + 1);
      check("timeout_err", bus.err, 32'(1) << w);
      check("timeout_no_done", bus.done, 0);
      pend[w] = 1'b0;
      apply_req();
      recover_tail();
    end else begin
      repeat (3) @(negedge clock);
      bus.eng_ready = 1'b1;  // arrives with reset; must not report
      do_reset();
      bus.eng_ready = 1'b0;
    end
  endtask

  // Cycle-level invariants.
  logic start_prev = 1'b0;
  always @(negedge clock) begin
    check("grant_onehot0", 32'($onehot0(bus.grant)), 1);
    check("single_pulse", 32'($countones(bus.done | bus.err) <= 1), 1);
    check("no_b2b_start", 32'(start_prev & bus.eng_start), 0);
    start_prev = bus.eng_start;
  end

  initial begin
    int k;
    int mode;
    logic any;
    for (int r = 0; r < NReq; r++) begin
      pend[r]   = 1'b0;
      m_read[r] = 1'b0;
      m_sa[r]   = '0;
      m_ra[r]   = '0;
      m_nb[r]   = '0;
      m_wd[r]   = '0;
    end
    bus.eng_data_req = 1'b0;
    bus.eng_ready    = 1'b0;
    bus.eng_error    = 1'b0;
    bus.eng_data_out = '0;
    apply_req();
    repeat (2) @(negedge clock);
    do_reset();

    // Single write
    new_cmd(1, 1'b0, 17'd2);
    m_sa[1] = 7'h29;
    m_ra[1] = 16'h0010;
    serve_round(ModeOk, 3, 16'h1234);

    // Contention with pointer at 0
    @(negedge clock);
    do_reset();
    for (int r = 0; r < NReq; r++) new_cmd(r, 1'b0, 17'($urandom_range(1, 20)));
    for (int i = 0; i < 5; i++) begin
      serve_round(ModeOk, 1, 16'h0);
      for (int r = 0; r < NReq; r++)
        if (!pend[r]) new_cmd(r, 1'b0, 17'($urandom_range(1, 20)));
    end

    // Read
    for (int r = 0; r < NReq; r++) pend[r] = 1'b0;
    new_cmd(2, 1'b1, 17'd2);
    serve_round(ModeOk, 0, 16'hABCD);

    // NACK, then the next requester
    new_cmd(0, 1'b0, 17'd5);
    new_cmd(3, 1'b0, 17'd3);
    serve_round(ModeErr, 0, 16'h0);
    serve_round(ModeOk, 2, 16'h0);

    // Timeout and zero length
    new_cmd(1, 1'b1, 17'd4);
    serve_round(ModeTmo, 0, 16'h0);
    new_cmd(2, 1'b0, 17'd0);
    serve_round(ModeOk, 0, 16'h0);

    // Reset mid-WAIT, then normal service
    new_cmd(3, 1'b0, 17'd4);
    serve_round(ModeRst, 0, 16'h0);
    serve_round(ModeOk, 1, 16'h0);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      any = 1'b0;
      for (int r = 0; r < NReq; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) new_cmd(r, 1'($urandom), rand_nb());
        any = any | pend[r];
      end
      if (!any) new_cmd(int'($urandom_range(0, NReq - 1)), 1'($urandom), rand_nb());
      k = int'($urandom_range(0, 9));
      mode = (k < 6) ? ModeOk : ((k < 9) ? ModeErr : ModeTmo);
      serve_round(mode, int'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
